// File: rtl/remap_accel_pkg.sv
// -----------------------------------------------------------------------------
// remap_accel_pkg
// Shared definitions for the remap accelerator address stage:
//   - default widths / multiplier latency
//   - sideband_t : per-coordinate data that travels beside the multiplier
//   - calc_addr  : base + product + zero-extended x, wrapping modulo 2^ADDR_W
// -----------------------------------------------------------------------------
package remap_accel_pkg;

  localparam int DEFAULT_COORD_W     = 16;
  localparam int DEFAULT_ADDR_W      = 32;
  localparam int DEFAULT_MUL_LATENCY = 4;

  // Everything about a coordinate except its y*stride product, which the
  // external multiplier carries in lock-step.
  typedef struct packed {
    logic                       valid;
    logic [DEFAULT_COORD_W-1:0] x;
    logic [DEFAULT_ADDR_W-1:0]  base;
    logic                       last;
    logic                       oob;
  } sideband_t;

  // All operands are unsigned; the sum wraps with no saturation.
  function automatic logic [DEFAULT_ADDR_W-1:0] calc_addr(
    input logic [DEFAULT_ADDR_W-1:0]    base,
    input logic [2*DEFAULT_COORD_W-1:0] product,
    input logic [DEFAULT_COORD_W-1:0]   x
  );
    return base + DEFAULT_ADDR_W'(product) + DEFAULT_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/remap_accel_addr_align.sv
// -----------------------------------------------------------------------------
// remap_accel_addr_align
// Clock-enabled shift register of sideband_t, DEPTH stages deep. It matches
// the external multiplier latency so each coordinate's x/base/last/oob leave
// in the same cycle as its product.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high; clears the stage valid bits only
//   i_ce   in   advance enable (shared with the multiplier)
//   i_sb   in   sideband entering stage 0
//   o_sb   out  sideband leaving the last stage
// -----------------------------------------------------------------------------
module remap_accel_addr_align
  import remap_accel_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MUL_LATENCY
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_ce,
  input  sideband_t i_sb,
  output sideband_t o_sb
);

  sideband_t r_stage [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the shift register into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the valid bits are reset. The payload is meaningless
      // while valid=0, so clearing it would add reset fan-out for nothing.
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i].valid <= 1'b0;
      end
    end else if (i_ce) begin
      r_stage[0] <= i_sb;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sb = r_stage[DEPTH-1];

endmodule

// File: rtl/remap_accel_addr_gen.sv
// -----------------------------------------------------------------------------
// remap_accel_addr_gen
// Pixel-address stage of the remap accelerator. It accepts (x, y) source
// coordinates and drives y and stride into an external MUL_LATENCY-cycle
// multiplier. When the product returns, it emits base + y*stride + x, one
// address per accepted coordinate, in order.
//
// The whole path is one lock-step pipeline of depth MUL_LATENCY+1:
//   - the multiplier stages
//   - one output register
// All stages share ce = m_ready | ~m_valid, so a stalled output freezes
// everything, including the multiplier. Bubbles keep their slot.
//
// Optional feature (macro REMAP_ADDR_OOB_EN):
//   Adds the m_oob port. A coordinate outside cfg_width x cfg_height is
//   flagged, and its address is forced to the frame base.
//
// The sideband struct is sized from remap_accel_pkg, so COORD_W/ADDR_W must
// keep the package values. MUL_LATENCY may change freely.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_base            frame base address (sampled at acceptance)
//   cfg_stride          line stride in pixels (sampled at acceptance)
//   cfg_width/height    image bounds (OOB build only)
//   s_valid/s_ready     input coordinate handshake
//   s_x/s_y/s_last      coordinate and end-of-line marker
//   mul_ce              multiplier clock enable
//   mul_din0/mul_din1   multiplier operands (y, stride)
//   mul_dout            product, MUL_LATENCY ce-cycles after operands
//   m_valid/m_ready     output address handshake
//   m_addr/m_last       address and aligned end-of-line marker
//   m_oob               out-of-bounds flag (OOB build only)
// -----------------------------------------------------------------------------
module remap_accel_addr_gen
  import remap_accel_pkg::*;
#(
  parameter int COORD_W     = DEFAULT_COORD_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [COORD_W-1:0]   cfg_stride,
  input  logic [COORD_W-1:0]   cfg_width,
  input  logic [COORD_W-1:0]   cfg_height,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [COORD_W-1:0]   s_x,
  input  logic [COORD_W-1:0]   s_y,
  input  logic                 s_last,
  output logic                 mul_ce,
  output logic [COORD_W-1:0]   mul_din0,
  output logic [COORD_W-1:0]   mul_din1,
  input  logic [2*COORD_W-1:0] mul_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ADDR_W-1:0]    m_addr,
`ifdef REMAP_ADDR_OOB_EN
  output logic                 m_oob,
`endif
  output logic                 m_last
);

  logic              w_ce;
  logic              w_oob;
  sideband_t         w_sb_in;
  sideband_t         w_sb_out;
  logic [ADDR_W-1:0] w_addr;

  logic              r_m_valid;
  logic [ADDR_W-1:0] r_m_addr;
  logic              r_m_last;

  // The output slot is free when it is empty or being drained.
  assign w_ce     = m_ready | ~r_m_valid;
  assign s_ready  = w_ce;
  assign mul_ce   = w_ce;

  // The multiplier registers its own operands, so these are driven raw.
  assign mul_din0 = s_y;
  assign mul_din1 = cfg_stride;

`ifdef REMAP_ADDR_OOB_EN
  assign w_oob = (s_x >= cfg_width) | (s_y >= cfg_height);
`else
  assign w_oob = 1'b0;
  logic w_unused_bounds;
  assign w_unused_bounds = ^{cfg_width, cfg_height};
`endif

  // NOTE: every field gets a default first, so no path through the block
  // leaves a field unassigned and no latch is inferred.
  always_comb begin
    w_sb_in       = '0;
    w_sb_in.valid = s_valid;  // a bubble enters with valid=0
    w_sb_in.x     = s_x;
    w_sb_in.base  = cfg_base;
    w_sb_in.last  = s_last;
    w_sb_in.oob   = w_oob;
  end

  remap_accel_addr_align #(
    .DEPTH (MUL_LATENCY)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .i_ce  (w_ce),
    .i_sb  (w_sb_in),
    .o_sb  (w_sb_out)
  );

  // An out-of-bounds coordinate points at the frame base; its product and x
  // are ignored.
  assign w_addr = w_sb_out.oob ? w_sb_out.base
                               : calc_addr(w_sb_out.base, mul_dout, w_sb_out.x);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_ce) begin
      r_m_valid <= w_sb_out.valid;
      r_m_addr  <= w_addr;
      r_m_last  <= w_sb_out.last;
    end
  end

`ifdef REMAP_ADDR_OOB_EN
  logic r_m_oob;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_oob <= 1'b0;
    end else if (w_ce) begin
      r_m_oob <= w_sb_out.oob;
    end
  end

  assign m_oob = r_m_oob;
`endif

  assign m_valid = r_m_valid;
  assign m_addr  = r_m_addr;
  assign m_last  = r_m_last;

endmodule

// File: tb/tb_remap_accel_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_remap_accel_addr_gen
// Directed bench for remap_accel_addr_gen. It also models the external
// 16x16 multiplier: a ce-enabled MUL_LATENCY-stage product pipeline.
// The OOB checks are compiled only when REMAP_ADDR_OOB_EN is defined.
// -----------------------------------------------------------------------------
module tb_remap_accel_addr_gen;

  localparam int COORD_W     = 16;
  localparam int ADDR_W      = 32;
  localparam int MUL_LATENCY = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADDR_W-1:0]    cfg_base;
  logic [COORD_W-1:0]   cfg_stride;
  logic [COORD_W-1:0]   cfg_width;
  logic [COORD_W-1:0]   cfg_height;
  logic                 s_valid;
  logic                 s_ready;
  logic [COORD_W-1:0]   s_x;
  logic [COORD_W-1:0]   s_y;
  logic                 s_last;
  logic                 mul_ce;
  logic [COORD_W-1:0]   mul_din0;
  logic [COORD_W-1:0]   mul_din1;
  logic [2*COORD_W-1:0] mul_dout;
  logic                 m_valid;
  logic                 m_ready;
  logic [ADDR_W-1:0]    m_addr;
  logic                 m_last;
`ifdef REMAP_ADDR_OOB_EN
  logic                 m_oob;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External multiplier model.
  logic [2*COORD_W-1:0] mul_pipe [MUL_LATENCY];
  always @(posedge clk) begin
    if (mul_ce) begin
      mul_pipe[0] <= 32'(mul_din0) * 32'(mul_din1);
      for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end
  assign mul_dout = mul_pipe[MUL_LATENCY-1];

  remap_accel_addr_gen #(
    .COORD_W     (COORD_W),
    .ADDR_W      (ADDR_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_y        (s_y),
    .s_last     (s_last),
    .mul_ce     (mul_ce),
    .mul_din0   (mul_din0),
    .mul_din1   (mul_din1),
    .mul_dout   (mul_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
`ifdef REMAP_ADDR_OOB_EN
    .m_oob      (m_oob),
`endif
    .m_last     (m_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_x     = '0;
    s_y     = '0;
    s_last  = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int stride,
                      input logic [31:0] base, input logic last);
    s_valid    = 1'b1;
    s_x        = COORD_W'(x);
    s_y        = COORD_W'(y);
    cfg_stride = COORD_W'(stride);
    cfg_base   = base;
    s_last     = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent;
    int          got;
    int          cyc;
    logic        stalled;
    logic [31:0] held;
    logic        exp_ready;

    reset      = 1'b1;
    m_ready    = 1'b1;
    cfg_base   = '0;
    cfg_stride = '0;
    cfg_width  = 16'd640;
    cfg_height = 16'd480;
    idle();
    repeat (3) step();
    reset = 1'b0;
    #1;

    // Post-reset state.
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_addr",  m_addr,  32'h0);
    check("rst_m_last",  m_last,  1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_mul_ce",  mul_ce,  1'b1);
`ifdef REMAP_ADDR_OOB_EN
    check("rst_m_oob",   m_oob,   1'b0);
`endif

    // Single coordinate: 0x1000_0000 + 2*640 + 3.
    send(3, 2, 640, 32'h1000_0000, 1'b1);
    #1;
    check("single_din0", mul_din0, 16'd2);
    check("single_din1", mul_din1, 16'd640);
    step();
    idle();
    for (int n = 1; n <= 6; n++) begin
      check("single_valid", m_valid, 1'(n == 5));
      if (n == 5) begin
        check("single_addr", m_addr, 32'h1000_0503);
        check("single_last", m_last, 1'b1);
      end
      step();
    end

    // cfg changes between back-to-back coordinates apply per coordinate.
    send(1, 1, 10, 32'd100, 1'b0);
    step();
    send(2, 3, 20, 32'd1000, 1'b1);
    step();
    idle();
    for (int n = 2; n <= 7; n++) begin
      check("cfg_valid", m_valid, 1'(n == 5 || n == 6));
      if (n == 5) begin
        check("cfg_addr0", m_addr, 32'd111);
        check("cfg_last0", m_last, 1'b0);
      end
      if (n == 6) begin
        check("cfg_addr1", m_addr, 32'd1062);
        check("cfg_last1", m_last, 1'b1);
      end
      step();
    end

    // 100 back-to-back coordinates, no backpressure.
    for (int c = 0; c < 110; c++) begin
      check("stream_valid", m_valid, 1'(c >= 5 && c < 105));
      if (c >= 5 && c < 105) check("stream_addr", m_addr, 64'(1025 * (c - 5)));
      if (c < 100) send(c, c, 1024, 32'h0, 1'b0);
      else         idle();
      #1;
      check("stream_s_ready", s_ready, 1'b1);
      step();
    end

    // Same stream with random 50% backpressure.
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (got < 100 && cyc < 3000) begin
      if (stalled) begin
        check("bp_hold_valid", m_valid, 1'b1);
        check("bp_hold_addr",  m_addr,  held);
      end
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 100) send(sent, sent, 1024, 32'h0, 1'b0);
      else            idle();
      #1;
      exp_ready = m_ready | ~m_valid;
      check("bp_s_ready", s_ready, exp_ready);
      check("bp_mul_ce",  mul_ce,  exp_ready);
      if (s_valid && exp_ready) sent++;
      stalled = m_valid & ~m_ready;
      held    = m_addr;
      if (m_valid && m_ready) begin
        check("bp_addr", m_addr, 64'(1025 * got));
        got++;
      end
      step();
      cyc++;
    end
    check("bp_count", got, 100);
    m_ready = 1'b1;
    idle();
    for (int n = 0; n < 8; n++) begin
      check("bp_no_extra", m_valid, 1'b0);
      step();
    end

    // Wrap-around, then a directed stall with a pending coordinate.
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1);
    step();
    idle();
    for (int n = 1; n <= 4; n++) begin
      check("wrap_wait", m_valid, 1'b0);
      step();
    end
    check("wrap_valid", m_valid, 1'b1);
    check("wrap_addr",  m_addr,  32'hFFFE_FFFF);
    check("wrap_last",  m_last,  1'b1);
    m_ready = 1'b0;
    send(5, 0, 1, 32'h100, 1'b0);
    #1;
    check("stall_s_ready", s_ready, 1'b0);
    check("stall_mul_ce",  mul_ce,  1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("stall_valid", m_valid, 1'b1);
      check("stall_addr",  m_addr,  32'hFFFE_FFFF);
      check("stall_last",  m_last,  1'b1);
    end
    m_ready = 1'b1;
    #1;
    check("resume_s_ready", s_ready, 1'b1);
    step();
    idle();
    for (int n = 1; n <= 5; n++) begin
      check("resume_valid", m_valid, 1'(n == 5));
      if (n == 5) check("resume_addr", m_addr, 32'h105);
      step();
    end

    // Reset with 4 coordinates in flight.
    for (int i = 0; i < 4; i++) begin
      send(i + 1, 0, 8, 32'h500, 1'b0);
      step();
    end
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    #1;
    check("midrst_valid",   m_valid, 1'b0);
    check("midrst_s_ready", s_ready, 1'b1);
    for (int n = 0; n < 6; n++) begin
      step();
      check("midrst_flush", m_valid, 1'b0);
    end
    send(7, 1, 16, 32'h2000, 1'b1);
    step();
    idle();
    for (int n = 1; n <= 5; n++) begin
      check("midrst_next_valid", m_valid, 1'(n == 5));
      if (n == 5) check("midrst_next_addr", m_addr, 32'h2017);
      step();
    end

`ifdef REMAP_ADDR_OOB_EN
    // Bounds 640x480: (640,0) and (0,480) are out; (639,479) is in.
    send(640, 0, 640, 32'h4000, 1'b0);
    step();
    send(0, 480, 640, 32'h4000, 1'b0);
    step();
    send(639, 479, 640, 32'h4000, 1'b1);
    step();
    idle();
    for (int n = 3; n <= 8; n++) begin
      check("oob_valid", m_valid, 1'(n >= 5 && n <= 7));
      if (n == 5 || n == 6) begin
        check("oob_flag", m_oob,  1'b1);
        check("oob_addr", m_addr, 32'h4000);
      end
      if (n == 7) begin
        check("inb_flag", m_oob,  1'b0);
        check("inb_addr", m_addr, 32'h0004_EFFF);
      end
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
